// File: rtl/cmp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cmp_pkg: op and FSM state encodings shared by the sequential         |
// | comparator. Revision: 1.0                                            |
// +----------------------------------------------------------------------+
package cmp_pkg;

  localparam logic [1:0] OP_SLT = 2'b00;
  localparam logic [1:0] OP_SLE = 2'b01;
  localparam logic [1:0] OP_SEQ = 2'b10;
  localparam logic [1:0] OP_SNE = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/chunk_cmp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | chunk_cmp: combinational compare of one CHUNK-wide operand slice.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module chunk_cmp #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             signed_top,
  output logic             diff,
  output logic             lt
);

  assign diff = (x != y);
  assign lt   = signed_top ? ($signed(x) < $signed(y)) : (x < y);

endmodule
`default_nettype wire

// File: rtl/seq_cmp_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_cmp_unit: multi-cycle set-on-compare, CHUNK bits per cycle,      |
// | MSB chunk first, with start/busy/done handshake. Revision: 1.0       |
// +----------------------------------------------------------------------+
module seq_cmp_unit
  import cmp_pkg::*;
#(
  parameter int N     = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         is_signed,
  input  logic [1:0]   op,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         lt,
  output logic         eq
);

  localparam int STEPS = N / CHUNK;
  localparam int IDX_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [IDX_W-1:0] C_IDX_TOP = IDX_W'(STEPS - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [N-1:0]     r_a;
  logic [N-1:0]     r_b;
  logic             r_signed;
  logic [1:0]       r_op;
  logic [IDX_W-1:0] r_idx;
  logic             r_decided;
  logic             r_lt_acc;
  logic [N-1:0]     r_result;
  logic             r_lt;
  logic             r_eq;

  logic             w_accept;
  logic             w_last;
  logic             w_diff;
  logic             w_chunk_lt;
  logic             w_lt_fin;
  logic             w_eq_fin;
  logic             w_res_bit;

  assign w_accept = start && (r_state != S_BUSY);
  assign w_last   = (r_idx == '0);

  // Operand copies shift left each step, so the active chunk is always the top slice.
  chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
    .x          (r_a[N-1 -: CHUNK]),
    .y          (r_b[N-1 -: CHUNK]),
    .signed_top (r_signed && (r_idx == C_IDX_TOP)),
    .diff       (w_diff),
    .lt         (w_chunk_lt)
  );

  // Final flags include the chunk being compared in the last BUSY cycle.
  assign w_lt_fin = r_decided ? r_lt_acc : w_chunk_lt;
  assign w_eq_fin = ~(r_decided | w_diff);

  always_comb begin
    w_res_bit = 1'b0;
    case (r_op)
      OP_SLT:  w_res_bit = w_lt_fin;
      OP_SLE:  w_res_bit = w_lt_fin | w_eq_fin;
      OP_SEQ:  w_res_bit = w_eq_fin;
      default: w_res_bit = ~w_eq_fin;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_BUSY;
      S_BUSY:  if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = start ? S_BUSY : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_signed  <= 1'b0;
      r_op      <= OP_SLT;
      r_idx     <= '0;
      r_decided <= 1'b0;
      r_lt_acc  <= 1'b0;
      r_result  <= '0;
      r_lt      <= 1'b0;
      r_eq      <= 1'b0;
    end else if (w_accept) begin
      r_a       <= a;
      r_b       <= b;
      r_signed  <= is_signed;
      r_op      <= op;
      r_idx     <= C_IDX_TOP;
      r_decided <= 1'b0;
      r_lt_acc  <= 1'b0;
    end else if (r_state == S_BUSY) begin
      if (!r_decided && w_diff) begin
        r_decided <= 1'b1;
        r_lt_acc  <= w_chunk_lt;
      end
      r_a <= r_a << CHUNK;
      r_b <= r_b << CHUNK;
      if (w_last) begin
        r_result <= N'(w_res_bit);
        r_lt     <= w_lt_fin;
        r_eq     <= w_eq_fin;
      end else begin
        r_idx <= r_idx - IDX_W'(1);
      end
    end
  end

  assign ready  = (r_state == S_IDLE) || (r_state == S_DONE);
  assign busy   = (r_state == S_BUSY);
  assign done   = (r_state == S_DONE);
  assign result = r_result;
  assign lt     = r_lt;
  assign eq     = r_eq;

endmodule
`default_nettype wire

// File: tb/tb_seq_cmp_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seq_cmp_unit: directed vectors with a scoreboard queue checked by |
// | an independent done-monitor. Revision: 1.0                           |
// +----------------------------------------------------------------------+
module tb_seq_cmp_unit;
  import cmp_pkg::*;

  localparam int N     = 32;
  localparam int CHUNK = 8;
  localparam int STEPS = N / CHUNK;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         is_signed;
  logic [1:0]   op;
  logic         ready;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         lt;
  logic         eq;

  typedef struct {
    logic [N-1:0] res;
    logic         lt;
    logic         eq;
    int           cyc;
    string        name;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;

  seq_cmp_unit #(.N(N), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .op        (op),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .lt        (lt),
    .eq        (eq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && done === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'd0);
      end else begin
        e = q.pop_front();
        chk({e.name, "_result"}, 64'(result), 64'(e.res));
        chk({e.name, "_lt"}, 64'(lt), 64'(e.lt));
        chk({e.name, "_eq"}, 64'(eq), 64'(e.eq));
        chk({e.name, "_latency"}, 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic push_exp(input logic er, input logic el, input logic ee, input string nm);
    q.push_back('{res: N'(er), lt: el, eq: ee, cyc: cyc + STEPS, name: nm});
  endtask

  // Drive one start pulse; returns #1 after the accepting edge.
  task automatic issue(input logic [N-1:0] ia, input logic [N-1:0] ib, input logic s,
                       input logic [1:0] iop, input logic er, input logic el,
                       input logic ee, input string nm, input bit do_push);
    @(negedge clk);
    a = ia; b = ib; is_signed = s; op = iop; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (do_push) push_exp(er, el, ee, nm);
  endtask

  task automatic wait_done(input string nm);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    chk({nm, "_done_seen"}, 64'(done), 64'd1);
  endtask

  task automatic run(input logic [N-1:0] ia, input logic [N-1:0] ib, input logic s,
                     input logic [1:0] iop, input logic er, input logic el,
                     input logic ee, input string nm);
    issue(ia, ib, s, iop, er, el, ee, nm, 1'b1);
    wait_done(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; is_signed = 1'b0; op = OP_SLT;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_lt", 64'(lt), 64'd0);
    chk("rst_eq", 64'(eq), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run(32'd10, 32'd4, 1'b1, OP_SLT, 1'b0, 1'b0, 1'b0, "slt_s_10_4");
    run(32'd4, 32'd10, 1'b1, OP_SLT, 1'b1, 1'b1, 1'b0, "slt_s_4_10");
    run(32'd10, 32'hFFFF_FFF8, 1'b1, OP_SLT, 1'b0, 1'b0, 1'b0, "slt_s_10_m8");
    run(32'd10, 32'hFFFF_FFF8, 1'b0, OP_SLT, 1'b1, 1'b1, 1'b0, "slt_u_10_m8");
    run(32'hFFFF_FFF8, 32'd10, 1'b1, OP_SLT, 1'b1, 1'b1, 1'b0, "slt_s_m8_10");
    run(32'hFFFF_FFF8, 32'd10, 1'b0, OP_SLT, 1'b0, 1'b0, 1'b0, "slt_u_m8_10");
    run(32'd8, 32'd8, 1'b1, OP_SLE, 1'b1, 1'b0, 1'b1, "sle_eq");
    run(32'd8, 32'd8, 1'b1, OP_SEQ, 1'b1, 1'b0, 1'b1, "seq_eq");
    run(32'd8, 32'd8, 1'b1, OP_SNE, 1'b0, 1'b0, 1'b1, "sne_eq");
    run(32'd8, 32'd8, 1'b1, OP_SLT, 1'b0, 1'b0, 1'b1, "slt_eq");
    run(32'd10, 32'd4, 1'b1, OP_SLE, 1'b0, 1'b0, 1'b0, "sle_gt");
    run(32'd10, 32'd4, 1'b1, OP_SNE, 1'b1, 1'b0, 1'b0, "sne_gt");
    run(32'h1234_5600, 32'h1234_5601, 1'b0, OP_SLT, 1'b1, 1'b1, 1'b0, "slt_low_chunk");

    // start while busy with other operands must be ignored
    issue(32'd4, 32'd10, 1'b1, OP_SLT, 1'b1, 1'b1, 1'b0, "busy_ignore", 1'b1);
    @(negedge clk);
    chk("busy_ignore_busy", 64'(busy), 64'd1);
    chk("busy_ignore_ready", 64'(ready), 64'd0);
    a = 32'd10; b = 32'd4; op = OP_SEQ; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = '0; b = '0;
    wait_done("busy_ignore");

    // start held during DONE chains the next compare immediately
    run(32'd5, 32'd3, 1'b0, OP_SLT, 1'b0, 1'b0, 1'b0, "chain_first");
    a = 32'd3; b = 32'd5; is_signed = 1'b0; op = OP_SLT; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("chain_busy", 64'(busy), 64'd1);
    push_exp(1'b1, 1'b1, 1'b0, "chain_second");
    wait_done("chain_second");

    // reset two cycles after accept aborts without a done pulse
    issue(32'd10, 32'd4, 1'b1, OP_SLT, 1'b0, 1'b0, 1'b0, "aborted", 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_ready", 64'(ready), 64'd1);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    @(negedge clk);
    start = 1'b1; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    chk("rst_beats_start_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (STEPS + 2) @(negedge clk);
    chk("abort_no_done", 64'(done), 64'd0);
    run(32'd3, 32'd5, 1'b0, OP_SLT, 1'b1, 1'b1, 1'b0, "after_abort");

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
